// File: rtl/router_pkg.sv
// Shared defaults and state encoding for the router source arbiter.
package router_pkg;

  localparam int unsigned NumSrcDefault    = 4;
  localparam int unsigned GapCyclesDefault = 2;
  localparam int unsigned MaxLenDefault    = 64;

  typedef enum logic [1:0] {
    StIdle,
    StXfer,
    StGap
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any_req
);

  int unsigned k;

  // Scan sources starting at ptr, wrapping, and keep the first hit.
  always_comb begin
    gnt     = '0;
    idx     = '0;
    any_req = 1'b0;
    k       = 0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      k = (32'(ptr) + i) % NUM_SRC;
      if (!any_req && req[k]) begin
        any_req = 1'b1;
        gnt[k]  = 1'b1;
        idx     = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/router_src_arbiter.sv
// Multiplexes NUM_SRC packet sources onto one router byte stream, one whole
// packet at a time, with round-robin fairness and a forced idle gap.
module router_src_arbiter
  import router_pkg::*;
#(
  parameter int unsigned NUM_SRC    = NumSrcDefault,
  parameter int unsigned GAP_CYCLES = GapCyclesDefault,
  parameter int unsigned MAX_LEN    = MaxLenDefault
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic [NUM_SRC-1:0][7:0]    src_data,
  input  logic [NUM_SRC-1:0]         src_last,
  output logic [NUM_SRC-1:0]         src_ready,
  input  logic                       busy,
  output logic [7:0]                 dut_inp,
  output logic                       inp_valid,
  output logic [$clog2(NUM_SRC)-1:0] grant_id,
  output logic                       grant_valid,
  output logic                       pkt_done,
  output logic                       len_err
);

  localparam int unsigned IdxW = $clog2(NUM_SRC);
  localparam int unsigned CntW = $clog2(MAX_LEN + 1);
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  arb_state_e          state_q, state_d;
  logic [IdxW-1:0]     grant_id_q, grant_id_d;
  logic [NUM_SRC-1:0]  gnt_oh_q, gnt_oh_d;
  logic [IdxW-1:0]     ptr_q, ptr_d;
  logic [CntW-1:0]     byte_cnt_q, byte_cnt_d;
  logic [GapW-1:0]     gap_cnt_q, gap_cnt_d;
  logic [7:0]          dut_inp_q, dut_inp_d;
  logic                inp_valid_q, inp_valid_d;
  logic                pkt_done_q, pkt_done_d;
  logic                len_err_q, len_err_d;

  logic [NUM_SRC-1:0]  rr_gnt;
  logic [IdxW-1:0]     rr_idx;
  logic                rr_any;
  logic                xfer_hs;
  logic                sel_last;
  logic [7:0]          sel_data;
  logic                at_max;

  rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IdxW)
  ) u_rr (
    .req     (src_valid),
    .ptr     (ptr_q),
    .gnt     (rr_gnt),
    .idx     (rr_idx),
    .any_req (rr_any)
  );

  assign src_ready   = (state_q == StXfer) ? gnt_oh_q : '0;
  assign grant_valid = (state_q == StXfer);
  assign xfer_hs     = |(src_valid & src_ready);
  assign sel_data    = src_data[grant_id_q];
  assign sel_last    = src_last[grant_id_q];
  assign at_max      = (byte_cnt_q == CntW'(MAX_LEN - 1));

  assign grant_id  = grant_id_q;
  assign dut_inp   = dut_inp_q;
  assign inp_valid = inp_valid_q;
  assign pkt_done  = pkt_done_q;
  assign len_err   = len_err_q;

  // Next-state and registered-output decode for the arbitration FSM.
  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    gnt_oh_d    = gnt_oh_q;
    ptr_d       = ptr_q;
    byte_cnt_d  = byte_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    dut_inp_d   = dut_inp_q;
    inp_valid_d = 1'b0;
    pkt_done_d  = 1'b0;
    len_err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!busy && rr_any) begin
          grant_id_d = rr_idx;
          gnt_oh_d   = rr_gnt;
          ptr_d      = (rr_idx == IdxW'(NUM_SRC - 1)) ? '0 : rr_idx + 1'b1;
          byte_cnt_d = '0;
          state_d    = StXfer;
        end
      end
      StXfer: begin
        if (xfer_hs) begin
          dut_inp_d   = sel_data;
          inp_valid_d = 1'b1;
          if (sel_last || at_max) begin
            // A forced cut at MAX_LEN leaves the rest of the source's bytes
            // to be arbitrated again as a fresh packet.
            pkt_done_d = 1'b1;
            len_err_d  = !sel_last;
            byte_cnt_d = '0;
            gap_cnt_d  = '0;
            state_d    = (GAP_CYCLES == 0) ? StIdle : StGap;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
      StGap: begin
        if (gap_cnt_q == GapW'(GAP_CYCLES - 1)) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      grant_id_q  <= '0;
      gnt_oh_q    <= '0;
      ptr_q       <= '0;
      byte_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      dut_inp_q   <= 8'h00;
      inp_valid_q <= 1'b0;
      pkt_done_q  <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      gnt_oh_q    <= gnt_oh_d;
      ptr_q       <= ptr_d;
      byte_cnt_q  <= byte_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      dut_inp_q   <= dut_inp_d;
      inp_valid_q <= inp_valid_d;
      pkt_done_q  <= pkt_done_d;
      len_err_q   <= len_err_d;
    end
  end

endmodule

// File: tb/tb_router_src_arbiter.sv
// Self-checking bench for router_src_arbiter: per-source byte queues feed the
// DUT, a scoreboard of expected output bytes is filled at each handshake.
module tb_router_src_arbiter;

  localparam int unsigned NUM_SRC    = 4;
  localparam int unsigned GAP_CYCLES = 2;
  localparam int unsigned MAX_LEN    = 64;
  localparam int unsigned IdxW       = $clog2(NUM_SRC);

  typedef struct packed {
    logic [7:0]      data;
    logic [IdxW-1:0] src;
    logic            done;
    logic            lerr;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic [NUM_SRC-1:0]      src_valid = '0;
  logic [NUM_SRC-1:0][7:0] src_data = '0;
  logic [NUM_SRC-1:0]      src_last = '0;
  logic [NUM_SRC-1:0]      src_ready;
  logic                    busy = 1'b0;
  logic [7:0]              dut_inp;
  logic                    inp_valid;
  logic [IdxW-1:0]         grant_id;
  logic                    grant_valid;
  logic                    pkt_done;
  logic                    len_err;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [8:0]         srcq [NUM_SRC][$];
  exp_t               sb [$];
  int                 done_log [$];
  int                 out_src [$];
  int                 out_cyc [$];
  int                 mcnt [NUM_SRC];
  logic [NUM_SRC-1:0] hold = '0;
  logic               hs_prev = 1'b0;
  int                 gap_watch = 0;
  int                 lerr_cnt = 0;

  router_src_arbiter #(
    .NUM_SRC    (NUM_SRC),
    .GAP_CYCLES (GAP_CYCLES),
    .MAX_LEN    (MAX_LEN)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .src_valid   (src_valid),
    .src_data    (src_data),
    .src_last    (src_last),
    .src_ready   (src_ready),
    .busy        (busy),
    .dut_inp     (dut_inp),
    .inp_valid   (inp_valid),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .pkt_done    (pkt_done),
    .len_err     (len_err)
  );

  always #5 clk = ~clk;

  // Source drivers: present the head of each queue unless held off.
  always @(posedge clk) begin
    #1;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (srcq[s].size() > 0 && !hold[s]) begin
        src_valid[s] = 1'b1;
        src_data[s]  = srcq[s][0][7:0];
        src_last[s]  = srcq[s][0][8];
      end else begin
        src_valid[s] = 1'b0;
        src_last[s]  = 1'b0;
      end
    end
  end

  // Monitor at mid-cycle: check last cycle's outputs, then log handshakes
  // that the coming rising edge will perform.
  always @(negedge clk) begin
    exp_t e;
    logic hs_now;
    logic [8:0] item;
    logic dn;
    cyc++;
    checks++;
    if (inp_valid !== hs_prev) begin
      errors++;
      $display("FAIL latency: inp_valid=%b expected %b cycle %0d", inp_valid, hs_prev, cyc);
    end
    if (inp_valid === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({dut_inp, grant_id, pkt_done, len_err} !== {e.data, e.src, e.done, e.lerr}) begin
        errors++;
        $display("FAIL output: got data=%h id=%0d done=%b lerr=%b, want data=%h id=%0d done=%b lerr=%b",
                 dut_inp, grant_id, pkt_done, len_err, e.data, e.src, e.done, e.lerr);
      end
      out_src.push_back(int'(grant_id));
      out_cyc.push_back(cyc);
      if (pkt_done === 1'b1) begin
        done_log.push_back(int'(grant_id));
        gap_watch = GAP_CYCLES;
      end
      if (len_err === 1'b1) lerr_cnt++;
    end else begin
      checks++;
      if (pkt_done !== 1'b0 || len_err !== 1'b0) begin
        errors++;
        $display("FAIL stray_pulse: pkt_done=%b len_err=%b want 0 0", pkt_done, len_err);
      end
      if (gap_watch > 0) begin
        gap_watch--;
        checks++;
        if (grant_valid !== 1'b0) begin
          errors++;
          $display("FAIL gap: grant_valid=%b want 0 during gap", grant_valid);
        end
      end
    end
    checks++;
    if (!$onehot0(src_ready) || (grant_valid !== 1'b1 && src_ready !== '0)) begin
      errors++;
      $display("FAIL ready: src_ready=%b grant_valid=%b", src_ready, grant_valid);
    end
    hs_now = 1'b0;
    if (reset !== 1'b1) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (src_valid[s] && src_ready[s] === 1'b1 && srcq[s].size() > 0) begin
          item = srcq[s].pop_front();
          mcnt[s]++;
          dn = item[8] || (mcnt[s] == MAX_LEN);
          e.data = item[7:0];
          e.src  = IdxW'(s);
          e.done = dn;
          e.lerr = !item[8] && (mcnt[s] == MAX_LEN);
          if (dn) mcnt[s] = 0;
          sb.push_back(e);
          hs_now = 1'b1;
        end
      end
    end
    hs_prev = hs_now;
  end

  task automatic push_pkt(input int s, input int len, input logic [7:0] base, input bit with_last);
    for (int i = 0; i < len; i++) begin
      srcq[s].push_back({with_last && (i == len - 1), base + 8'(i)});
    end
  endtask

  task automatic clear_logs();
    done_log.delete();
    out_src.delete();
    out_cyc.delete();
    lerr_cnt = 0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    bit empty;
    n = 0;
    empty = 1'b0;
    while (!empty && n < budget) begin
      @(negedge clk);
      #2;
      n++;
      empty = (sb.size() == 0);
      for (int s = 0; s < NUM_SRC; s++) if (srcq[s].size() != 0) empty = 1'b0;
    end
    checks++;
    if (!empty) begin
      errors++;
      $display("FAIL %s_timeout: queues not drained after %0d cycles", name, budget);
    end
    repeat (GAP_CYCLES + 3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    for (int s = 0; s < NUM_SRC; s++) begin
      srcq[s].delete();
      mcnt[s] = 0;
    end
    sb.delete();
    hs_prev = 1'b0;
    hold = '0;
    busy = 1'b0;
    gap_watch = 0;
    @(negedge clk);
    checks++;
    if ({dut_inp, inp_valid, grant_valid, grant_id, pkt_done, len_err, src_ready} !==
        {8'h00, 1'b0, 1'b0, IdxW'(0), 1'b0, 1'b0, {NUM_SRC{1'b0}}}) begin
      errors++;
      $display("FAIL reset_values: data=%h v=%b gv=%b id=%0d done=%b lerr=%b rdy=%b",
               dut_inp, inp_valid, grant_valid, grant_id, pkt_done, len_err, src_ready);
    end
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_single_packet();
    clear_logs();
    @(negedge clk);
    #2;
    push_pkt(0, 3, 8'hA1, 1'b1);
    wait_drain("single", 50);
    checks++;
    if (out_src.size() != 3 || done_log.size() != 1) begin
      errors++;
      $display("FAIL single_count: bytes=%0d dones=%0d want 3 1", out_src.size(), done_log.size());
    end else begin
      checks++;
      if (out_cyc[2] - out_cyc[0] != 2) begin
        errors++;
        $display("FAIL single_consecutive: span=%0d want 2", out_cyc[2] - out_cyc[0]);
      end
    end
  endtask

  task automatic test_round_robin();
    int exp_order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    clear_logs();
    push_pkt(0, 2, 8'h10, 1'b1);
    push_pkt(0, 2, 8'h18, 1'b1);
    push_pkt(1, 2, 8'h20, 1'b1);
    push_pkt(2, 2, 8'h30, 1'b1);
    push_pkt(3, 2, 8'h40, 1'b1);
    wait_drain("rr", 200);
    checks++;
    if (done_log.size() != 5) begin
      errors++;
      $display("FAIL rr_count: packets=%0d want 5", done_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (done_log[i] != exp_order[i]) begin
          errors++;
          $display("FAIL rr_order[%0d]: got %0d want %0d", i, done_log[i], exp_order[i]);
        end
      end
    end
  endtask

  task automatic test_busy();
    clear_logs();
    @(negedge clk);
    #2;
    busy = 1'b1;
    push_pkt(1, 2, 8'h55, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (src_ready !== '0 || inp_valid !== 1'b0) begin
        errors++;
        $display("FAIL busy_block: src_ready=%b inp_valid=%b want 0 0", src_ready, inp_valid);
      end
    end
    #2;
    busy = 1'b0;
    @(negedge clk);
    checks++;
    if (grant_valid !== 1'b1 || grant_id !== IdxW'(1)) begin
      errors++;
      $display("FAIL busy_release: grant_valid=%b id=%0d want 1 1", grant_valid, grant_id);
    end
    wait_drain("busy", 50);
  endtask

  task automatic test_len_err();
    clear_logs();
    @(negedge clk);
    #2;
    push_pkt(2, 70, 8'h00, 1'b0);
    wait_drain("len", 300);
    checks++;
    if (out_src.size() != 70 || lerr_cnt != 1 || done_log.size() != 1) begin
      errors++;
      $display("FAIL len_counts: bytes=%0d lerr=%0d dones=%0d want 70 1 1",
               out_src.size(), lerr_cnt, done_log.size());
    end else begin
      checks++;
      if (out_cyc[64] - out_cyc[63] < GAP_CYCLES + 1) begin
        errors++;
        $display("FAIL len_gap: spacing=%0d want >= %0d", out_cyc[64] - out_cyc[63], GAP_CYCLES + 1);
      end
    end
    checks++;
    if (grant_valid !== 1'b1 || grant_id !== IdxW'(2)) begin
      errors++;
      $display("FAIL len_tail_open: grant_valid=%b id=%0d want 1 2", grant_valid, grant_id);
    end
    do_reset();
  endtask

  task automatic test_reset_mid_packet();
    int n;
    clear_logs();
    @(negedge clk);
    #2;
    push_pkt(1, 5, 8'hC0, 1'b1);
    n = 0;
    while (srcq[1].size() != 3 && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    checks++;
    if (srcq[1].size() != 3) begin
      errors++;
      $display("FAIL midrst_timeout: remaining=%0d want 3", srcq[1].size());
    end
    do_reset();
    checks++;
    if (done_log.size() != 0) begin
      errors++;
      $display("FAIL midrst_no_done: dones=%0d want 0", done_log.size());
    end
    push_pkt(3, 2, 8'hD3, 1'b1);
    push_pkt(0, 2, 8'hD0, 1'b1);
    wait_drain("midrst", 100);
    checks++;
    if (done_log.size() != 2 || done_log[0] != 0 || done_log[1] != 3) begin
      errors++;
      $display("FAIL midrst_order: count=%0d first=%0d want 2 packets, 0 then 3",
               done_log.size(), (done_log.size() > 0) ? done_log[0] : -1);
    end
  endtask

  task automatic test_stall();
    int n;
    clear_logs();
    @(negedge clk);
    #2;
    push_pkt(0, 4, 8'hE0, 1'b1);
    push_pkt(3, 2, 8'hF0, 1'b1);
    n = 0;
    while (srcq[0].size() != 3 && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    hold[0] = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    hold[0] = 1'b0;
    wait_drain("stall", 100);
    checks++;
    if (out_src.size() != 6 || done_log.size() != 2) begin
      errors++;
      $display("FAIL stall_count: bytes=%0d dones=%0d want 6 2", out_src.size(), done_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (out_src[i] != ((i < 4) ? 0 : 3)) begin
          errors++;
          $display("FAIL stall_src[%0d]: got %0d want %0d", i, out_src[i], (i < 4) ? 0 : 3);
        end
      end
      checks++;
      if (out_cyc[3] - out_cyc[0] != 5) begin
        errors++;
        $display("FAIL stall_span: got %0d want 5", out_cyc[3] - out_cyc[0]);
      end
      checks++;
      if (out_cyc[4] - out_cyc[3] < GAP_CYCLES + 1) begin
        errors++;
        $display("FAIL stall_gap: spacing=%0d want >= %0d", out_cyc[4] - out_cyc[3], GAP_CYCLES + 1);
      end
    end
  endtask

  initial begin
    for (int s = 0; s < NUM_SRC; s++) mcnt[s] = 0;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_busy();
    test_len_err();
    test_reset_mid_packet();
    test_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
